led_fader: RTL and testbench

Output-side LED driver. It takes the logical LED register produced by the button/shift logic and drives the physical LED pins. Each channel gets global-brightness PWM, and a channel that turns off fades out exponentially instead of going dark at once. Two single-cycle pulses (from the existing debounce/single-pulse chain) step the global brightness up and down.

---
 rtl/led_fader.sv | 92 +++++++++
 tb/tb_led_fader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_fader.sv
// LED pin driver: global-brightness PWM per channel, with an exponential fade-out
// for channels that switch off. Brightness is stepped by single-cycle up/down pulses.
module led_fader #(
  parameter int WIDTH    = 8,
  parameter int FADE_DIV = 1_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] led_in,
  input  logic             bright_up,
  input  logic             bright_down,
  output logic [WIDTH-1:0] led_out,
  output logic [2:0]       level
);

  localparam int              PW        = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(FADE_DIV - 1);

  // Duty is a run of (level+1) ones: 1, 3, 7, ... 255.
  function automatic logic [7:0] duty_of(input logic [2:0] lvl);
    duty_of = 8'hFF >> (3'd7 - lvl);
  endfunction

  function automatic logic [7:0] fade_next(input logic [7:0] cur, input logic [7:0] duty,
                                           input logic on, input logic tick);
    logic [7:0] clamped;
    clamped = (cur < duty) ? cur : duty;
    if (on) begin
      fade_next = duty;
    end else if (tick) begin
      fade_next = clamped >> 1;
    end else begin
      fade_next = clamped;
    end
  endfunction

  logic [PW-1:0] presc_r;
  logic [7:0]    pwm_cnt_r;
  logic [7:0]    inten_r     [WIDTH];
  logic [7:0]    inten_nxt_s [WIDTH];
  logic [7:0]    duty_s;
  logic          tick_s;

  // Next-state intensity for every channel from the current level and fade tick.
  always_comb begin
    tick_s = (presc_r == PRESC_MAX);
    duty_s = duty_of(level);
    for (int i = 0; i < WIDTH; i++) begin
      inten_nxt_s[i] = fade_next(inten_r[i], duty_s, led_in[i], tick_s);
    end
  end

  // Free-running PWM counter and fade prescaler.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt_r <= 8'd0;
      presc_r   <= '0;
    end else begin
      pwm_cnt_r <= (pwm_cnt_r == 8'd254) ? 8'd0 : pwm_cnt_r + 8'd1;
      presc_r   <= tick_s ? '0 : presc_r + PW'(1);
    end
  end

  // Saturating brightness level; simultaneous up and down cancel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level <= 3'd7;
    end else begin
      case ({bright_up, bright_down})
        2'b10: level <= (level != 3'd7) ? level + 3'd1 : level;
        2'b01: level <= (level != 3'd0) ? level - 3'd1 : level;
        default: level <= level;
      endcase
    end
  end

  // Channel intensities and registered PWM pin drive.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        inten_r[i] <= 8'd0;
      end
      led_out <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        inten_r[i] <= inten_nxt_s[i];
        led_out[i] <= (pwm_cnt_r < inten_r[i]);
      end
    end
  end

endmodule

// File: tb/tb_led_fader.sv
// Self-checking bench for led_fader: cycle-level reference model plus
// hand-computed PWM window counts for brightness, fade and reset scenarios.
module tb_led_fader;

  localparam int FD = 255;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] led_in;
  logic       bright_up;
  logic       bright_down;
  logic [7:0] led_out;
  logic [2:0] level;

  int checks = 0;
  int errors = 0;

  led_fader #(.WIDTH(8), .FADE_DIV(FD)) dut (
    .clk(clk), .rst_n(rst_n), .led_in(led_in), .bright_up(bright_up),
    .bright_down(bright_down), .led_out(led_out), .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: brightness level, PWM phase, fade timer and channel intensities as integers.
  int         m_level;
  int         m_pwm;
  int         m_presc;
  int         m_inten [8];
  logic [7:0] m_out;
  bit         model_valid = 1'b0;

  function automatic int m_next(int cur, bit on, int lvl, bit tk);
    int duty;
    int c;
    duty = (1 << (lvl + 1)) - 1;
    c = (cur < duty) ? cur : duty;
    if (on) return duty;
    if (tk) return c / 2;
    return c;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_level     <= 7;
      m_pwm       <= 0;
      m_presc     <= 0;
      m_out       <= 8'h00;
      model_valid <= 1'b1;
      for (int i = 0; i < 8; i++) m_inten[i] <= 0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        m_out[i]   <= (m_pwm < m_inten[i]);
        m_inten[i] <= m_next(m_inten[i], led_in[i], m_level, m_presc == FD - 1);
      end
      m_pwm   <= (m_pwm + 1) % 255;
      m_presc <= (m_presc + 1) % FD;
      if (bright_up && !bright_down && m_level < 7) m_level <= m_level + 1;
      else if (bright_down && !bright_up && m_level > 0) m_level <= m_level - 1;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("led_out_vs_model", {24'd0, led_out}, {24'd0, m_out});
      chk("level_vs_model", {29'd0, level}, m_level);
    end
  end

  task automatic pulse(input bit up, input bit dn);
    bright_up = up;
    bright_down = dn;
    @(negedge clk);
    bright_up = 1'b0;
    bright_down = 1'b0;
    @(negedge clk);
  endtask

  // Align to the negedge whose led_out sample reflects pwm phase 0.
  task automatic sync_window();
    int n = 0;
    while (m_pwm != 1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("sync_timeout", m_pwm, 1);
  endtask

  task automatic count_window(input int nd, input bit pu,
                              output int c0, output int chi, output int cfull);
    c0 = 0; chi = 0; cfull = 0;
    for (int k = 0; k < 255; k++) begin
      c0 += int'(led_out[0]);
      if (led_out[7:1] != 7'd0) chi++;
      if (led_out == 8'hFF) cfull++;
      bright_down = (k < 2 * nd) && (k % 2 == 0);
      bright_up   = pu && (k == 0);
      @(negedge clk);
    end
    bright_up = 1'b0;
    bright_down = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int c0, chi, cfull, bad, hi_total;
  int exp_fade [10] = '{255, 127, 63, 31, 15, 7, 3, 1, 0, 0};
  int exp_clamp [4] = '{7, 3, 1, 0};

  initial begin
    rst_n = 1'b0;
    led_in = 8'hFF;
    bright_up = 1'b0;
    bright_down = 1'b0;

    // Reset with inputs active
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_led_out", {24'd0, led_out}, 32'd0);
      chk("reset_level", {29'd0, level}, 32'd7);
    end
    rst_n = 1'b1;
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (led_out != 8'hFF) bad++;
    end
    chk("post_reset_steady_ff", bad, 0);

    // Brightness floor
    repeat (7) pulse(1'b0, 1'b1);
    chk("floor_level", {29'd0, level}, 32'd0);
    repeat (4) @(negedge clk);
    sync_window();
    count_window(0, 1'b0, c0, chi, cfull);
    chk("floor_window_full", cfull, 1);
    chk("floor_window_bit0", c0, 1);
    pulse(1'b0, 1'b1);
    chk("floor_saturate", {29'd0, level}, 32'd0);
    repeat (8) pulse(1'b1, 1'b0);
    chk("ceiling_level", {29'd0, level}, 32'd7);
    repeat (4) @(negedge clk);
    sync_window();
    count_window(0, 1'b0, c0, chi, cfull);
    chk("ceiling_window_full", cfull, 255);

    // Simultaneous pulses at level 4
    repeat (3) pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b1);
    chk("simul_level", {29'd0, level}, 32'd4);
    repeat (4) @(negedge clk);
    sync_window();
    count_window(0, 1'b0, c0, chi, cfull);
    chk("simul_window_full", cfull, 31);

    // Fade-out from level 7
    led_in = 8'h01;
    do_reset(2);
    repeat (5) @(negedge clk);
    sync_window();
    led_in = 8'h00;
    hi_total = 0;
    for (int w = 0; w < 10; w++) begin
      count_window(0, 1'b0, c0, chi, cfull);
      chk($sformatf("fade_window_%0d", w), c0, exp_fade[w]);
      hi_total += chi;
    end
    chk("fade_other_bits_dark", hi_total, 0);

    // Clamp while fading, then no revival on bright_up
    led_in = 8'h01;
    do_reset(2);
    repeat (5) @(negedge clk);
    sync_window();
    led_in = 8'h00;
    count_window(0, 1'b0, c0, chi, cfull);
    chk("clamp_first_window", c0, 255);
    count_window(4, 1'b0, c0, chi, cfull);
    chk("clamp_level", {29'd0, level}, 32'd3);
    for (int w = 0; w < 4; w++) begin
      count_window(0, w == 0, c0, chi, cfull);
      chk($sformatf("clamp_window_%0d", w), c0, exp_clamp[w]);
      if (w == 0) chk("clamp_up_level", {29'd0, level}, 32'd4);
    end

    // Reset mid-fade
    led_in = 8'hFF;
    repeat (10) @(negedge clk);
    led_in = 8'h00;
    repeat (300) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midfade_reset_out", {24'd0, led_out}, 32'd0);
    chk("midfade_reset_level", {29'd0, level}, 32'd7);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (led_out != 8'h00) bad++;
    end
    chk("midfade_stays_dark", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
